reg_dump_reader: RTL
====================

Name: reg_dump_reader

Overview:
- Debug/verification reader for the RV32I register file. It sweeps a contiguous range of architectural registers through one register-file read port and streams each value out with a valid/ready handshake.
- Sits beside the datapath. Its read-address output is muxed onto a register-file read port while the core is halted. Its output stream feeds the debug/trace unit.
- Read-only; never drives the register-file write port.

Parameters:
- XLEN, 32, register data width.
- ADDR_W, 5, register index width (32 registers).
- FORCE_X0_ZERO, 1, when 1, index 0 is emitted as 0 regardless of rd_data.

Ports:
- clk  input  1  single clock; all state on posedge.
- reset  input  1  synchronous, active-high.
- start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
- abort  input  1  synchronous cancel of an active dump.
- first_reg  input  ADDR_W  first register index; latched on accepted start.
- last_reg  input  ADDR_W  last register index (inclusive); latched on accepted start.
- rd_addr  output  ADDR_W  read address to the register-file read port.
- rd_data  input  XLEN  combinational read data for rd_addr, valid in the same cycle.
- dump_valid  output  1  beat valid.
- dump_ready  input  1  consumer accepts the beat.
- dump_data  output  XLEN  register value.
- dump_idx  output  ADDR_W  register index of the beat.
- dump_last  output  1  beat is the final one of the range.
- busy  output  1  high in READ or SEND.
- done  output  1  one-cycle pulse at the end of the dump.
- err  output  1  one-cycle pulse, coincident with done, on an illegal range.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high. Polarity and synchronicity are fixed.
- Reset: state IDLE, and all outputs (rd_addr, dump_valid, dump_data, dump_idx, dump_last, busy, done, err) are 0. Reset mid-dump discards the dump with no done pulse.
- States: IDLE, READ, SEND, FIN.
- IDLE:
  - start with first_reg <= last_reg: latch cur=first_reg, end=last_reg; go to READ.
  - start with first_reg > last_reg: go to FIN with err flagged; no beats are emitted.
  - start outside IDLE is ignored.
- READ:
  - Drive rd_addr=cur.
  - At the clock edge, register dump_data=rd_data (or 0 if cur==0 and FORCE_X0_ZERO), dump_idx=cur, dump_last=(cur==end).
  - Set dump_valid=1 and go to SEND.
- SEND:
  - Hold dump_valid and all dump_* fields stable until dump_ready=1.
  - On handshake: if dump_last, go to FIN; otherwise cur=cur+1 and go to READ.
  - dump_valid deasserts in the cycle after the handshake.
- FIN: done=1 (and err=1 if flagged) for exactly one cycle; next state IDLE.
- Timing:
  - Throughput is one beat per 2 cycles with dump_ready held high.
  - Latency from start to first dump_valid is 2 cycles.
  - rd_addr holds cur in all non-IDLE states and 0 in IDLE.
- Wrap-around: the cur increment never wraps, because end <= 31 stops the sweep first. A range of 31..31 emits one beat.
- abort (READ or SEND):
  - Next state is IDLE, and dump_valid drops the next cycle even without a handshake. This is a documented exception to the hold rule.
  - No done pulse.
  - abort in IDLE or FIN has no effect.
  - abort and dump_ready in the same cycle: abort wins; the beat counts as not delivered.
- Simultaneous start and reset: reset wins.

Decomposition:
- Shared package rv32_dbg_pkg holds:
  - the state enum (IDLE/READ/SEND/FIN);
  - XLEN_DEF=32 and REG_ADDR_W=5, also used by reg_file consumers;
  - the constant REG_ZERO=5'd0.
- No sub-module. FSM, index counter and output holding register sit in one module. An optional port mux onto the register file lives at core top level, not here.

Test Plan:
- Reset, then start with first=0, last=3, dump_ready=1, register file preloaded x1=0x11, x2=0x22, x3=0x33 -> 4 beats, idx 0..3, data 0, 0x11, 0x22, 0x33. dump_last only on idx 3. done pulses 1 cycle after the last handshake. First valid appears 2 cycles after start.
- Backpressure: first=5, last=6, dump_ready low for 3 cycles on the first beat -> dump_data/dump_idx=5 held stable for all 3 stall cycles; 2 beats total; no duplication.
- Illegal range: first=9, last=4 -> no dump_valid. done=1 and err=1 for one cycle, 1 cycle after start. busy stays 0.
- Abort in SEND during range 0..31 on idx 7 with dump_ready=0 -> IDLE next cycle, dump_valid=0, no done. A following start with 31..31 yields a single beat idx 31 with dump_last=1.
- FORCE_X0_ZERO=1 with a stub rd_data returning 0xDEADBEEF at addr 0 -> beat idx 0 carries data 0.
- Reset asserted in READ at idx 2, plus start asserted during busy -> all outputs 0 after the edge. The mid-dump start is ignored, with no extra beats or done.

Source files
------------

// File: rtl/rv32_dbg_pkg.sv
// Shared debug-path definitions for RV32I register-file readers.
package rv32_dbg_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2,
    ST_FIN  = 2'd3
  } dump_state_e;

endpackage

// File: rtl/reg_dump_reader.sv
// Sweeps registers first_reg..last_reg through one read port and streams
// each value out on a valid/ready channel, ending with a done (and err) pulse.
module reg_dump_reader
  import rv32_dbg_pkg::*;
#(
  parameter int XLEN          = XLEN_DEF,
  parameter int ADDR_W        = REG_ADDR_W,
  parameter bit FORCE_X0_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [XLEN-1:0]   rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [XLEN-1:0]   dump_data,
  output logic [ADDR_W-1:0] dump_idx,
  output logic              dump_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic              err_q, err_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              dlast_q, dlast_d;

  // x0 is architecturally zero; optionally mask whatever the port returns.
  function automatic logic [XLEN-1:0] beat_data(input logic [ADDR_W-1:0] idx,
                                                input logic [XLEN-1:0]   d);
    if (FORCE_X0_ZERO && (idx == ADDR_W'(REG_ZERO))) begin
      return '0;
    end
    return d;
  endfunction

  // Next-state, index counter and beat holding register.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    last_d  = last_q;
    err_d   = err_q;
    data_d  = data_q;
    idx_d   = idx_q;
    dlast_d = dlast_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (first_reg <= last_reg) begin
            cur_d   = first_reg;
            last_d  = last_reg;
            err_d   = 1'b0;
            state_d = ST_READ;
          end else begin
            // Illegal range: report straight away without emitting beats.
            err_d   = 1'b1;
            state_d = ST_FIN;
          end
        end
      end
      ST_READ: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          data_d  = beat_data(cur_q, rd_data);
          idx_d   = cur_q;
          dlast_d = (cur_q == last_q);
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        // Abort takes priority over a same-cycle handshake.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (dump_ready) begin
          if (dlast_q) begin
            state_d = ST_FIN;
          end else begin
            // Cannot wrap: last_q <= max index stops the sweep first.
            cur_d   = cur_q + ADDR_W'(1);
            state_d = ST_READ;
          end
        end
      end
      ST_FIN: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything visible at the ports.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      last_q  <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      dlast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      err_q   <= err_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      dlast_q <= dlast_d;
    end
  end

  assign rd_addr    = (state_q == ST_IDLE) ? '0 : cur_q;
  assign dump_valid = (state_q == ST_SEND);
  assign dump_data  = data_q;
  assign dump_idx   = idx_q;
  assign dump_last  = dlast_q;
  assign busy       = (state_q == ST_READ) || (state_q == ST_SEND);
  assign done       = (state_q == ST_FIN);
  assign err        = (state_q == ST_FIN) && err_q;

endmodule
